torus_xbar_alloc: RTL and testbench
===================================

Name: torus_xbar_alloc

Overview:
- Slot-based switch allocator and sequencer for the bit-serial 1-bit torus crossbar.
- Each packet is PKT_LEN bits shifted serially. At every slot boundary the block samples the north (N), west (W) and PE (P) requests and computes the crossbar select lines.
- It holds those selects for the whole next slot and reports grants, deflection and output-valid to the router shell.
- Routing policy is bufferless deflection:
  - N has fixed priority.
  - W is always accepted and may be deflected.
  - P injects only into a free port, with starvation relief.

Parameters:
- PKT_LEN, 16, bits per packet = cycles per slot (>=2).
- STARVE_MAX, 4, consecutive denied slots before P is boosted (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- n_req  in  1  packet arriving on north input next slot (always routed south).
- w_req  in  1  packet arriving on west input next slot.
- w_dir  in  1  W preferred port: 0=east, 1=south.
- p_req  in  1  PE wants to inject next slot.
- p_dir  in  1  P requested port: 0=east, 1=south.
- slot_last  out  1  high in the sampling cycle (slot_cnt==PKT_LEN-1).
- n2s  out  1  crossbar select: south<-N.
- w2s  out  1  crossbar select: south<-W.
- w2e  out  1  crossbar select: east<-W.
- p2s  out  1  informational: south<-P.
- p2e  out  1  informational: east<-P.
- so_vld  out  1  south output carries a packet this slot.
- eo_vld  out  1  east output carries a packet this slot.
- p_gnt  out  1  P owns a port this slot; PE shifts its packet out.
- w_defl  out  1  W routed opposite to w_dir this slot.

Behaviour:
- Slot counter:
  - slot_cnt counts 0..PKT_LEN-1 and wraps.
  - slot_last = (slot_cnt==PKT_LEN-1), combinational from the counter.
- Sampling:
  - Requests are sampled only on the rising edge that ends a cycle with slot_last=1.
  - The allocation computed from them is registered and held constant for the next PKT_LEN cycles.
  - Request values at other cycles are ignored.
- Allocation, evaluated in this order:
  - 1) n_req=1: N takes south.
  - 2) boost = (starve_cnt==STARVE_MAX). P is pre-allocated before W if all of these hold:
    - boost and p_req.
    - Port p_dir is free.
    - W is either absent, or can take the port opposite p_dir and that port is free.
  - 3) w_req=1: W takes w_dir if free, else the other port with w_defl=1.
    - W always gets a port, because N can only take south.
  - 4) p_req=1 and not yet allocated: P takes p_dir only if free. P is never deflected; otherwise it is denied.
- Select encoding, chosen to match the mux priority so>n2s>w2s>P and eo>w2e>P:
  - P on south: n2s=0, w2s=0, p2s=1.
  - P on east: w2e=0, p2e=1.
  - Unused port: all its selects 0, vld 0.
- Valid and grant outputs:
  - so_vld = south allocated; eo_vld = east allocated.
  - p_gnt = P allocated.
  - All of these are registered and held with the selects.
- Starvation counter (starve_cnt):
  - At each boundary: p_req and not granted → increment, saturating at STARVE_MAX.
  - P granted or p_req=0 → clear to 0.
- Reset (asynchronous, rst_n=0):
  - slot_cnt=0, starve_cnt=0.
  - All select, vld, gnt and defl outputs 0.
  - Mid-slot reset aborts the current slot immediately; no partial config survives.
  - After release, the first boundary occurs at cycle PKT_LEN-1.
- Illegal case: n_req with both W and P wanting south is resolved purely by the rules above. No error flag.

Test Plan:
- Reset release, PKT_LEN=16, all req=0 → slot_last first high in cycle 15; all outputs 0 throughout; reset asserted mid-slot zeroes outputs within the same cycle.
- n_req=1, w_req=1 w_dir=1 at boundary → next slot n2s=1, w2e=1, w_defl=1, so_vld=eo_vld=1; config stable 16 cycles, then cleared when reqs drop.
- w_req=1 w_dir=0, p_req=1 p_dir=1, n_req=0 → w2e=1, p2s=1, p_gnt=1, n2s=w2s=0, w_defl=0.
- n_req=1, w_req=1 w_dir=0, p_req=1 p_dir=0 held 5 slots → p_gnt=0 every slot, starve_cnt saturates at 4; N on south and W on east keep both ports, so P stays denied (no boost path).
- n_req=0, w_req=1 w_dir=0, p_req=1 p_dir=0 for 5 slots → slots 1-4: W east, P denied; slot 5 (boost): p2e=1, p_gnt=1, w2s=1, w_defl=1; starve_cnt returns to 0.
- Requests toggled at non-boundary cycles → no effect on outputs until the next slot_last sample.

Source files
------------

// File: rtl/torus_xbar_alloc.sv
// -----------------------------------------------------------------------------
// torus_xbar_alloc
//
// Slot-based switch allocator and sequencer for the bit-serial 1-bit torus
// crossbar. Every packet is PKT_LEN bits long and moves one bit per cycle, so
// one slot is PKT_LEN cycles. In the last cycle of each slot the north (N),
// west (W) and PE (P) requests are sampled. The resulting crossbar selects,
// valids, grant and deflection flag are registered and held for the whole
// following slot.
//
// Routing is bufferless deflection:
//   - N has fixed priority and always goes south.
//   - W is always accepted and may be deflected to the other port.
//   - P injects only into a free port. After STARVE_MAX consecutive denied
//     slots, P is allowed to claim its port ahead of W.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   n_req      packet on north input next slot (always routed south)
//   w_req      packet on west input next slot
//   w_dir      W preferred port: 0 = east, 1 = south
//   p_req      PE wants to inject next slot
//   p_dir      P requested port: 0 = east, 1 = south
//   slot_last  high in the sampling cycle (last cycle of a slot)
//   n2s        crossbar select south <- N
//   w2s        crossbar select south <- W
//   w2e        crossbar select east  <- W
//   p2s        informational: south <- P
//   p2e        informational: east  <- P
//   so_vld     south output carries a packet this slot
//   eo_vld     east output carries a packet this slot
//   p_gnt      P owns a port this slot
//   w_defl     W routed opposite to w_dir this slot
// -----------------------------------------------------------------------------
module torus_xbar_alloc #(
    parameter int PKT_LEN    = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic n_req,
    input  logic w_req,
    input  logic w_dir,
    input  logic p_req,
    input  logic p_dir,
    output logic slot_last,
    output logic n2s,
    output logic w2s,
    output logic w2e,
    output logic p2s,
    output logic p2e,
    output logic so_vld,
    output logic eo_vld,
    output logic p_gnt,
    output logic w_defl
);

    localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;

    logic n2s_q, w2s_q, w2e_q, p2s_q, p2e_q;
    logic so_vld_q, eo_vld_q, p_gnt_q, w_defl_q;

    logic n2s_d, w2s_d, w2e_d, p2s_d, p2e_d;
    logic so_vld_d, eo_vld_d, p_gnt_d, w_defl_d;

    logic boost;
    logic south_taken, east_taken;
    logic p_port_free, p_opp_free;

    // Free-running slot position; the last count marks the sampling cycle.
    assign slot_last = (slot_cnt_q == CNT_LAST);
    assign slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;

    // Allocation for the coming slot, from the requests present at the
    // sampling cycle. Ports are claimed in priority order N, boosted P, W,
    // then normal P. W's fallback port is always free: N only takes south,
    // and a boosted P leaves W's alternative port open.
    always_comb begin
        n2s_d       = 1'b0;
        w2s_d       = 1'b0;
        w2e_d       = 1'b0;
        p2s_d       = 1'b0;
        p2e_d       = 1'b0;
        w_defl_d    = 1'b0;
        south_taken = 1'b0;
        east_taken  = 1'b0;
        boost       = (starve_cnt_q == STARVE_TOP);

        if (n_req) begin
            n2s_d       = 1'b1;
            south_taken = 1'b1;
        end

        p_port_free = p_dir ? !south_taken : !east_taken;
        p_opp_free  = p_dir ? !east_taken  : !south_taken;

        if (boost && p_req && p_port_free && (!w_req || p_opp_free)) begin
            p2s_d       = p_dir;
            p2e_d       = !p_dir;
            south_taken = south_taken | p_dir;
            east_taken  = east_taken  | !p_dir;
        end

        if (w_req) begin
            if (w_dir ? !south_taken : !east_taken) begin
                w2s_d = w_dir;
                w2e_d = !w_dir;
            end else begin
                w2s_d    = !w_dir;
                w2e_d    = w_dir;
                w_defl_d = 1'b1;
            end
            south_taken = south_taken | w2s_d;
            east_taken  = east_taken  | w2e_d;
        end

        if (p_req && !(p2s_d || p2e_d)) begin
            if (p_dir && !south_taken) begin
                p2s_d = 1'b1;
            end else if (!p_dir && !east_taken) begin
                p2e_d = 1'b1;
            end
        end

        so_vld_d = n2s_d | w2s_d | p2s_d;
        eo_vld_d = w2e_d | p2e_d;
        p_gnt_d  = p2s_d | p2e_d;

        if (p_req && !p_gnt_d) begin
            starve_cnt_d = boost ? starve_cnt_q : starve_cnt_q + 1'b1;
        end else begin
            starve_cnt_d = '0;
        end
    end

    // Slot counter runs every cycle. Allocation and starvation state change
    // only at slot boundaries and are held for the whole next slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            starve_cnt_q <= '0;
            n2s_q        <= 1'b0;
            w2s_q        <= 1'b0;
            w2e_q        <= 1'b0;
            p2s_q        <= 1'b0;
            p2e_q        <= 1'b0;
            so_vld_q     <= 1'b0;
            eo_vld_q     <= 1'b0;
            p_gnt_q      <= 1'b0;
            w_defl_q     <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            if (slot_last) begin
                starve_cnt_q <= starve_cnt_d;
                n2s_q        <= n2s_d;
                w2s_q        <= w2s_d;
                w2e_q        <= w2e_d;
                p2s_q        <= p2s_d;
                p2e_q        <= p2e_d;
                so_vld_q     <= so_vld_d;
                eo_vld_q     <= eo_vld_d;
                p_gnt_q      <= p_gnt_d;
                w_defl_q     <= w_defl_d;
            end
        end
    end

    assign n2s    = n2s_q;
    assign w2s    = w2s_q;
    assign w2e    = w2e_q;
    assign p2s    = p2s_q;
    assign p2e    = p2e_q;
    assign so_vld = so_vld_q;
    assign eo_vld = eo_vld_q;
    assign p_gnt  = p_gnt_q;
    assign w_defl = w_defl_q;

endmodule

// File: tb/tb_torus_xbar_alloc.sv
// -----------------------------------------------------------------------------
// tb_torus_xbar_alloc
//
// Directed bench for torus_xbar_alloc. A driver applies one request vector per
// slot at the sampling cycle and pushes the hand-computed configuration for
// the following slot into a queue. Between samples the driver scrambles the
// request inputs, which must be ignored. A monitor pops the queue after every
// slot boundary and compares the output bundle, then confirms the bundle stays
// unchanged for the rest of the slot.
//
// Output bundle order: {n2s, w2s, w2e, p2s, p2e, so_vld, eo_vld, p_gnt, w_defl}
// -----------------------------------------------------------------------------
module tb_torus_xbar_alloc;

    localparam int PKT_LEN    = 16;
    localparam int STARVE_MAX = 4;

    typedef logic [8:0] vec_t;

    // Named configurations, hand-derived from the routing rules.
    localparam vec_t IDLE      = 9'b000000000;
    localparam vec_t N_S_W_E_D = 9'b101001101; // N south, W deflected east
    localparam vec_t W_E_P_S   = 9'b001101110; // W east, P south granted
    localparam vec_t N_S_W_E   = 9'b101001100; // N south, W east, P denied
    localparam vec_t W_E       = 9'b001000100; // W east only, P denied
    localparam vec_t BOOST_P_E = 9'b010011111; // P east boosted, W deflected south
    localparam vec_t P_E       = 9'b000010110; // P alone on east
    localparam vec_t W_S       = 9'b010001000; // W alone on south
    localparam vec_t N_S       = 9'b100001000; // N south, P south denied

    logic clk;
    logic rst_n;
    logic n_req, w_req, w_dir, p_req, p_dir;
    logic slot_last;
    logic n2s, w2s, w2e, p2s, p2e, so_vld, eo_vld, p_gnt, w_defl;

    int   checks;
    int   fails;
    vec_t sbQ[$];
    vec_t curExp;
    bit   monEnable;

    torus_xbar_alloc #(
        .PKT_LEN   (PKT_LEN),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .n_req    (n_req),
        .w_req    (w_req),
        .w_dir    (w_dir),
        .p_req    (p_req),
        .p_dir    (p_dir),
        .slot_last(slot_last),
        .n2s      (n2s),
        .w2s      (w2s),
        .w2e      (w2e),
        .p2s      (p2s),
        .p2e      (p2e),
        .so_vld   (so_vld),
        .eo_vld   (eo_vld),
        .p_gnt    (p_gnt),
        .w_defl   (w_defl)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t outVec();
        return {n2s, w2s, w2e, p2s, p2e, so_vld, eo_vld, p_gnt, w_defl};
    endfunction

    // Single comparison point; every check steps the counters here.
    task automatic checkOutput(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Waits for the sampling cycle, drives one request vector there, queues
    // the expected next-slot configuration and then scrambles the inputs for
    // the rest of the slot.
    task automatic applyStimulus(input logic n, input logic w, input logic wd,
                                 input logic p, input logic pd, input vec_t exp);
        int guard;
        guard = 0;
        while (!slot_last && guard < 2 * PKT_LEN) begin
            @(negedge clk);
            guard++;
        end
        if (!slot_last) begin
            checks++;
            fails++;
            $display("[TB] FAIL slot_timeout: got no slot_last expected slot_last within %0d cycles", 2 * PKT_LEN);
        end
        n_req = n;
        w_req = w;
        w_dir = wd;
        p_req = p;
        p_dir = pd;
        sbQ.push_back(exp);
        @(negedge clk);
        {n_req, w_req, w_dir, p_req, p_dir} = 5'($urandom);
    endtask

    // Monitor: after each boundary compare against the queued expectation,
    // otherwise confirm the held configuration has not moved.
    initial begin
        curExp = IDLE;
        forever begin
            @(negedge clk);
            if (monEnable && rst_n) begin
                if (slot_last) begin
                    @(posedge clk);
                    #1;
                    if (sbQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL sb_empty: got boundary expected queued entry at %0t", $time);
                    end else begin
                        curExp = sbQ.pop_front();
                        checkOutput("slot_cfg", outVec(), curExp);
                    end
                end else begin
                    checkOutput("slot_hold", outVec(), curExp);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        fails     = 0;
        monEnable = 1'b1;
        rst_n     = 1'b0;
        {n_req, w_req, w_dir, p_req, p_dir} = 5'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First boundary must land in cycle PKT_LEN-1 after release.
        for (int k = 0; k < PKT_LEN; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("slot_last_c%0d", k), vec_t'(slot_last),
                        vec_t'(k == PKT_LEN - 1));
        end

        applyStimulus(0, 0, 0, 0, 0, IDLE);
        applyStimulus(1, 1, 1, 0, 0, N_S_W_E_D);
        applyStimulus(1, 1, 1, 0, 0, N_S_W_E_D);
        applyStimulus(0, 0, 0, 0, 0, IDLE);
        applyStimulus(0, 1, 0, 1, 1, W_E_P_S);

        // N south and W east leave nothing for P, even once boosted.
        for (int s = 0; s < 5; s++) applyStimulus(1, 1, 0, 1, 0, N_S_W_E);
        applyStimulus(0, 0, 0, 0, 0, IDLE);

        // Four denied slots, then the boosted slot, then back to normal.
        for (int s = 0; s < 4; s++) applyStimulus(0, 1, 0, 1, 0, W_E);
        applyStimulus(0, 1, 0, 1, 0, BOOST_P_E);
        applyStimulus(0, 1, 0, 1, 0, W_E);

        applyStimulus(0, 0, 0, 1, 0, P_E);
        applyStimulus(0, 1, 1, 0, 0, W_S);
        applyStimulus(1, 0, 0, 1, 1, N_S);
        applyStimulus(1, 1, 1, 1, 1, N_S_W_E_D);
        applyStimulus(0, 0, 0, 0, 0, IDLE);

        monEnable = 1'b0;
        checks++;
        if (sbQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL sb_drain: got %0d entries expected 0", sbQ.size());
        end

        // Mid-slot reset must clear the configuration immediately.
        begin
            int guard;
            guard = 0;
            while (!slot_last && guard < 2 * PKT_LEN) begin
                @(negedge clk);
                guard++;
            end
        end
        {n_req, w_req, w_dir, p_req, p_dir} = 5'b11100;
        @(negedge clk);
        {n_req, w_req, w_dir, p_req, p_dir} = 5'b0;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset", outVec(), N_S_W_E_D);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", outVec(), IDLE);
        checkOutput("reset_slot_last", vec_t'(slot_last), IDLE);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (PKT_LEN - 2) @(negedge clk);
        checkOutput("post_reset_c14", vec_t'(slot_last), IDLE);
        @(negedge clk);
        checkOutput("post_reset_c15", vec_t'(slot_last), vec_t'(1));
        checkOutput("post_reset_idle", outVec(), IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
